// File: rtl/pwm_bank_pkg.sv
// Shared types and constants for the pwm_bank PWM generator.
// The optional PWM_CENTER_ALIGN_EN macro (see pwm_bank.sv) does not touch this package.
package pwm_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_t;

    localparam int PWM_NUM_CH_MIN     = 1;
    localparam int PWM_NUM_CH_MAX     = 16;
    localparam int PWM_WIDTH_MIN      = 4;
    localparam int PWM_WIDTH_MAX      = 16;

    localparam int DEFAULT_NUM_CH     = 4;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/pwm_bank_if.sv
// Control/status bundle between the command layer (master) and pwm_bank (slave).
interface pwm_bank_if
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) ();

    logic                    enable;
    logic [PRESCALE_W-1:0]   prescale;
    logic [WIDTH-1:0]        period;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH*WIDTH-1:0] duty;
    logic [NUM_CH-1:0]       update;
    logic [NUM_CH-1:0]       update_done;
    logic                    period_start;
    logic                    busy;
    logic [NUM_CH-1:0]       pwm_out;

    modport master (
        output enable, prescale, period, ch_enable, duty, update,
        input  update_done, period_start, busy, pwm_out
    );

    modport slave (
        input  enable, prescale, period, ch_enable, duty, update,
        output update_done, period_start, busy, pwm_out
    );

endinterface

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered duty/enable, load acknowledge and output compare.
module pwm_bank_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_boundary,
    input  logic             i_busy,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_duty,
    input  logic             i_update,
    input  logic             i_ch_enable,
    output logic             o_update_done,
    output logic             o_pwm_out
);

    logic [WIDTH-1:0] r_duty_act;
    logic             r_ch_en_act;
    logic             r_update_done;
    logic             r_pwm_out;

    // Shadow registers only move at period boundaries so the waveform never glitches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_duty_act    <= '0;
            r_ch_en_act   <= 1'b0;
            r_update_done <= 1'b0;
            r_pwm_out     <= 1'b0;
        end else begin
            r_update_done <= i_boundary && i_update;
            r_pwm_out     <= i_busy && r_ch_en_act && (i_cnt < r_duty_act);
            if (i_boundary) begin
                r_ch_en_act <= i_ch_enable;
                if (i_update) begin
                    r_duty_act <= i_duty;
                end
            end
        end
    end

    assign o_update_done = r_update_done;
    assign o_pwm_out     = r_pwm_out;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaled timebase plus NUM_CH compare channels.
// Optional macro PWM_CENTER_ALIGN_EN selects an up/down (center-aligned) counter;
// without it the counter is edge-aligned (0..P, wrap).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | counter and prescaler parked at 0, outputs low
// ST_RUN  | timebase running; stop only at a wrap boundary
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic       clock,
    input  logic       reset_n,
    pwm_bank_if.slave  bus
);

    pwm_state_t            r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_p_act;
    logic                  r_busy;
    logic                  r_period_start;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_start;
    logic                  w_boundary;
    logic [WIDTH-1:0]      w_cnt_nxt;
    logic [NUM_CH-1:0]     w_update_done;
    logic [NUM_CH-1:0]     w_pwm_out;

`ifdef PWM_CENTER_ALIGN_EN
    logic                  r_down;
    logic                  w_down_nxt;

    // Up/down count 0..P..1; a peak of P=1 turns straight back to 0, P=0 stays at 0.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_down_nxt = r_down;
        if (r_down) begin
            w_cnt_nxt  = r_cnt - 1'b1;
            w_down_nxt = (r_cnt != WIDTH'(1));
        end else if (r_cnt == r_p_act) begin
            w_cnt_nxt  = (r_p_act == '0) ? '0 : r_cnt - 1'b1;
            w_down_nxt = (r_p_act > WIDTH'(1));
        end else begin
            w_cnt_nxt  = r_cnt + 1'b1;
        end
    end
`else
    // Edge-aligned count 0..P then wrap.
    always_comb begin
        w_cnt_nxt = (r_cnt == r_p_act) ? '0 : r_cnt + 1'b1;
    end
`endif

    // >= keeps the prescaler from running away if prescale is lowered mid-period.
    assign w_tick     = (r_state == ST_RUN) && (r_presc >= bus.prescale);
    assign w_wrap     = w_tick && (w_cnt_nxt == '0);
    assign w_start    = (r_state == ST_IDLE) && bus.enable;
    // A wrap with enable low is the stop point, not the start of a new period.
    assign w_boundary = w_start || (w_wrap && bus.enable);

    // Timebase FSM with registered busy/period_start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_p_act        <= '0;
            r_busy         <= 1'b0;
            r_period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            r_down         <= 1'b0;
`endif
        end else begin
            r_period_start <= w_boundary;
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_presc <= '0;
`ifdef PWM_CENTER_ALIGN_EN
                    r_down  <= 1'b0;
`endif
                    if (bus.enable) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_p_act <= bus.period;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_presc <= '0;
`ifdef PWM_CENTER_ALIGN_EN
                        r_down  <= w_wrap ? 1'b0 : w_down_nxt;
`endif
                        if (w_wrap) begin
                            r_cnt <= '0;
                            if (bus.enable) begin
                                r_p_act <= bus.period;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_bank_channel #(.WIDTH(WIDTH)) u_ch (
            .clock         (clock),
            .reset_n       (reset_n),
            .i_boundary    (w_boundary),
            .i_busy        (r_busy),
            .i_cnt         (r_cnt),
            .i_duty        (bus.duty[i*WIDTH +: WIDTH]),
            .i_update      (bus.update[i]),
            .i_ch_enable   (bus.ch_enable[i]),
            .o_update_done (w_update_done[i]),
            .o_pwm_out     (w_pwm_out[i])
        );
    end

    assign bus.busy         = r_busy;
    assign bus.period_start = r_period_start;
    assign bus.update_done  = w_update_done;
    assign bus.pwm_out      = w_pwm_out;

endmodule
